// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, full-duplex, single clock domain.
// Optional back-to-back bursts under `SPI_MASTER_BURST_EN: a start on the
// edge that ends HOLD chains the next word with cs_n held low.
module spi_master #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_IDLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  localparam int unsigned CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned BIT_W   = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_div, w_div_nxt;
  logic [BIT_W-1:0]   r_bit, w_bit_nxt;
  logic [WIDTH-1:0]   r_tx, w_tx_nxt;
  logic [WIDTH-1:0]   r_rx, w_rx_nxt;
  logic [WIDTH-1:0]   r_dout, w_dout_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_sclk, w_sclk_nxt;
  logic               r_cs_n, w_cs_n_nxt;
  logic               r_mosi, w_mosi_nxt;
  logic               w_div_last;
  logic               w_gap_last;
  logic               w_chain;

`ifdef SPI_MASTER_BURST_EN
  assign w_chain = start;
`else
  assign w_chain = 1'b0;
`endif

  assign w_div_last = (r_div == CNT_W'(CLK_DIV - 1));
  assign w_gap_last = (r_div == CNT_W'(CS_IDLE - 1));

  assign busy = r_busy;
  assign done = r_done;
  assign dout = r_dout;
  assign sclk = r_sclk;
  assign cs_n = r_cs_n;
  assign mosi = r_mosi;

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_dout  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_mosi  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      r_rx    <= w_rx_nxt;
      r_dout  <= w_dout_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_sclk  <= w_sclk_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_mosi  <= w_mosi_nxt;
    end
  end

  // Next-state and next-output decode; every phase ends when the divider wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_tx_nxt    = r_tx;
    w_rx_nxt    = r_rx;
    w_dout_nxt  = r_dout;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_sclk_nxt  = r_sclk;
    w_cs_n_nxt  = r_cs_n;
    w_mosi_nxt  = r_mosi;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start) begin
          w_tx_nxt    = din;
          w_bit_nxt   = '0;
          w_div_nxt   = '0;
          w_cs_n_nxt  = 1'b0;
          w_sclk_nxt  = 1'b0;
          w_mosi_nxt  = din[WIDTH-1];
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_div_last) begin
          w_div_nxt   = '0;
          w_sclk_nxt  = 1'b1;
          w_state_nxt = S_HIGH;
        end else begin
          w_div_nxt = r_div + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (w_div_last) begin
          w_div_nxt  = '0;
          w_sclk_nxt = 1'b0;
          w_rx_nxt   = {r_rx[WIDTH-2:0], miso};
          if (r_bit == BIT_W'(WIDTH - 1)) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_bit_nxt   = r_bit + BIT_W'(1);
            w_tx_nxt    = {r_tx[WIDTH-2:0], 1'b0};
            w_mosi_nxt  = r_tx[WIDTH-2];
            w_state_nxt = S_LOW;
          end
        end else begin
          w_div_nxt = r_div + CNT_W'(1);
        end
      end
      S_LOW: begin
        if (w_div_last) begin
          w_div_nxt   = '0;
          w_sclk_nxt  = 1'b1;
          w_state_nxt = S_HIGH;
        end else begin
          w_div_nxt = r_div + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (w_div_last) begin
          w_div_nxt  = '0;
          w_dout_nxt = r_rx;
          w_done_nxt = 1'b1;
          if (w_chain) begin
            // Chained word: reload as IDLE would, but keep cs_n low.
            w_tx_nxt    = din;
            w_bit_nxt   = '0;
            w_mosi_nxt  = din[WIDTH-1];
            w_state_nxt = S_SETUP;
          end else begin
            w_cs_n_nxt  = 1'b1;
            w_mosi_nxt  = 1'b0;
            w_state_nxt = S_GAP;
          end
        end else begin
          w_div_nxt = r_div + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (w_gap_last) begin
          w_div_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_div_nxt = r_div + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Randomised self-checking bench for spi_master with a behavioural mode-0 slave.
module tb_spi_master;

  localparam int unsigned W      = 8;
  localparam int unsigned CD     = 2;
  localparam int unsigned CI     = 2;
  localparam int unsigned T_DONE = CD * (2 * W + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] din = '0;
  logic         miso = 1'b0;
  logic         busy, done, sclk, cs_n, mosi;
  logic [W-1:0] dout;

  spi_master #(.WIDTH(W), .CLK_DIV(CD), .CS_IDLE(CI)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .busy(busy), .done(done),
    .dout(dout), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Slave model: presents the MSB while selected, advances one bit per sclk fall;
  // also records mosi at each sclk rise.
  logic [2*W-1:0] s_stream = '0;
  logic [2*W-1:0] mosi_cap = '0;
  int unsigned    s_idx = 0;
  int unsigned    rise_cnt = 0;
  logic           prev_sclk = 1'b0;
  logic           last_bit = 1'b0;

  always @(negedge clk) begin
    if (cs_n) s_idx = 0;
    else if (prev_sclk && !sclk) s_idx++;
    if (!prev_sclk && sclk) begin
      rise_cnt++;
      mosi_cap = {mosi_cap[2*W-2:0], mosi};
      last_bit = mosi;
    end else if (prev_sclk && sclk && !cs_n) begin
      check_eq("mosi_hold", mosi, last_bit);
    end
    miso = (s_idx < 2 * W) ? s_stream[2*W-1-s_idx] : 1'b0;
    prev_sclk = sclk;
  end

  int unsigned last_done = 0;
  bit          have_last = 0;

  task automatic run_word(input logic [W-1:0] mtx, input logic [W-1:0] stx,
                          input int unsigned extra, input bit spurious);
    int unsigned e0, t, k;
    t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    check_eq("idle_wait", busy, 0);
    repeat (extra) @(negedge clk);
    s_stream = {stx, W'(0)};
    rise_cnt = 0;
    mosi_cap = '0;
    din = mtx;
    start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    din = W'($urandom);
    check_eq("accept_cs_n", cs_n, 0);
    check_eq("accept_busy", busy, 1);
    check_eq("accept_mosi", mosi, mtx[W-1]);
    if (have_last) check_eq("cs_gap", e0 - last_done, CI + 1 + extra);
    k = $urandom_range(0, T_DONE - CD - 1);
    t = 0;
    while (!done && t < T_DONE + 20) begin
      if (spurious && t == k) begin start = 1'b1; din = '1; end
      else start = 1'b0;
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    check_eq("done_seen", done, 1);
    check_eq("done_latency", cyc - e0, T_DONE);
    check_eq("done_cs_n", cs_n, 1);
    check_eq("done_busy", busy, 1);
    check_eq("done_mosi", mosi, 0);
    check_eq("dout", dout, stx);
    check_eq("mosi_bits", mosi_cap[W-1:0], mtx);
    check_eq("sclk_rises", rise_cnt, W);
    last_done = cyc;
    have_last = 1;
    @(negedge clk);
    check_eq("done_pulse", done, 0);
    check_eq("dout_held", dout, stx);
    t = 0;
    while (busy && t < 50) begin @(negedge clk); t++; end
    check_eq("busy_release", cyc - last_done, CI);
  endtask

  task automatic reset_mid(input logic [W-1:0] mtx, input logic [W-1:0] stx);
    int unsigned t;
    bit saw_done;
    t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    s_stream = {stx, W'(0)};
    rise_cnt = 0;
    din = mtx;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    saw_done = 0;
    t = 0;
    while (rise_cnt < 4 && t < T_DONE) begin
      @(negedge clk);
      if (done) saw_done = 1;
      t++;
    end
    check_eq("mid_rises", rise_cnt, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_cs_n", cs_n, 1);
    check_eq("mid_sclk", sclk, 0);
    check_eq("mid_dout", dout, 0);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_mosi", mosi, 0);
    check_eq("mid_done", done | saw_done, 0);
    have_last = 0;
  endtask

`ifdef SPI_MASTER_BURST_EN
  task automatic burst_pair(input logic [W-1:0] s1, input logic [W-1:0] s2);
    int unsigned e0, d1, t;
    t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    s_stream = {s1, s2};
    rise_cnt = 0;
    mosi_cap = '0;
    din = 8'h11;
    start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    din = 8'h22;
    t = 0;
    while (!done && t < T_DONE + 20) begin @(negedge clk); t++; end
    start = 1'b0;
    check_eq("b1_latency", cyc - e0, T_DONE);
    check_eq("b1_dout", dout, s1);
    check_eq("b1_cs_n", cs_n, 0);
    check_eq("b1_busy", busy, 1);
    d1 = cyc;
    @(negedge clk);
    t = 0;
    while (!done && t < T_DONE + 20) begin
      if (cs_n) check_eq("b_cs_low", cs_n, 0);
      @(negedge clk);
      t++;
    end
    check_eq("b2_spacing", cyc - d1, T_DONE);
    check_eq("b2_dout", dout, s2);
    check_eq("b2_rises", rise_cnt, 2 * W);
    check_eq("b2_mosi", mosi_cap, 16'h1122);
    check_eq("b2_cs_n", cs_n, 1);
    have_last = 0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, stopping");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_sclk", sclk, 0);
    check_eq("rst_cs_n", cs_n, 1);
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_dout", dout, 0);

    run_word(8'hA5, 8'h3C, 0, 1'b0);
    run_word(8'hC3, 8'h5A, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      run_word(W'($urandom), W'($urandom), $urandom_range(0, 3), 1'($urandom));
    end
    reset_mid(8'hF0, 8'h81);
    run_word(8'h96, 8'h69, 1, 1'b0);
`ifdef SPI_MASTER_BURST_EN
    burst_pair(8'hE7, 8'h18);
    run_word(8'h3D, 8'hB2, 0, 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
